// File: rtl/pad_loop_tester.sv
// pad_loop_tester
//   Built-in self-test for the south-edge pad loopback pair. A PRBS7 stream
//   (x^7+x^6+1) is driven out of loop_pad_s_6 and sampled back on
//   loop_pad_s_7 through a LATENCY-deep synchronizer. Each returned bit is
//   compared against a delayed copy of what was sent. The checker counts
//   mismatches (saturating) and records the index of the first failing bit.
//
// Ports
//   clk, rst_n     core clock, asynchronous active-low reset
//   start          single-cycle test request, accepted in IDLE only
//   abort          cancels a running test (RUN/DRAIN)
//   length         number of pattern bits, sampled on start (0 = ignored)
//   seed           PRBS7 seed, sampled on start (0 replaced by 7'h01)
//   loop_out       pattern bit to the loop pad output driver
//   loop_oe        output enable for the loop pad driver
//   loop_in        raw asynchronous return from the partner loop pad
//   busy           high in RUN and DRAIN
//   done           one-cycle pulse at normal completion
//   pass           last completed test had zero errors
//   err_count      saturating mismatch count
//   first_err_idx  index of first mismatched bit, all-ones if none
module pad_loop_tester #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned ERR_W   = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] length,
  input  logic [6:0]       seed,
  output logic             loop_out,
  output logic             loop_oe,
  input  logic             loop_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [LEN_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t             state;
  logic [6:0]         lfsr;       // state for the next bit to launch
  logic [LEN_W-1:0]   last_idx;   // length-1, captured on start
  logic [LEN_W-1:0]   tx_idx;     // index of bit currently on loop_out
  logic [LEN_W-1:0]   rx_idx;     // index of bit at the checker
  logic               tx_vld;     // loop_out carries a freshly launched bit
  logic [LATENCY-1:0] sync_q;
  logic [LATENCY-1:0] exp_q;
  logic [LATENCY-1:0] vld_q;

  logic [6:0] seed_eff;
  logic       chk_vld;
  logic       chk_err;
  logic       chk_last;
  logic       do_abort;

  function automatic logic [6:0] prbs_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  always_comb begin
    seed_eff = (seed == 7'h00) ? 7'h01 : seed;
    chk_vld  = vld_q[LATENCY-1];
    chk_err  = chk_vld && (sync_q[LATENCY-1] != exp_q[LATENCY-1]);
    chk_last = chk_vld && (rx_idx == last_idx);
    do_abort = abort && ((state == ST_RUN) || (state == ST_DRAIN));
  end

  // Plain synchronizer on the asynchronous pad return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[LATENCY-2:0], loop_in};
    end
  end

  // The expected-bit pipeline is fed from the registered loop_out, so its
  // tail lines up with the synchronizer tail exactly LATENCY edges after
  // a bit is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      lfsr          <= '0;
      last_idx      <= '0;
      tx_idx        <= '0;
      rx_idx        <= '0;
      tx_vld        <= 1'b0;
      exp_q         <= '0;
      vld_q         <= '0;
      loop_out      <= 1'b0;
      loop_oe       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '1;
    end else begin
      exp_q <= {exp_q[LATENCY-2:0], loop_out};
      vld_q <= {vld_q[LATENCY-2:0], tx_vld};
      done  <= 1'b0;

      // Checker; a partial result is frozen on the abort edge.
      if (chk_vld && !do_abort) begin
        rx_idx <= rx_idx + 1'b1;
        if (chk_err) begin
          if (err_count != '1) begin
            err_count <= err_count + 1'b1;
          end
          if (first_err_idx == '1) begin
            first_err_idx <= rx_idx;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          loop_out <= 1'b0;
          loop_oe  <= 1'b0;
          if (start && (length != '0)) begin
            // Bit 0 is launched on the accepting edge itself.
            state         <= ST_RUN;
            loop_out      <= seed_eff[6];
            lfsr          <= prbs_next(seed_eff);
            loop_oe       <= 1'b1;
            busy          <= 1'b1;
            tx_idx        <= '0;
            tx_vld        <= 1'b1;
            rx_idx        <= '0;
            last_idx      <= length - 1'b1;
            err_count     <= '0;
            first_err_idx <= '1;
            pass          <= 1'b0;
          end
        end

        ST_RUN: begin
          if (do_abort) begin
            state    <= ST_IDLE;
            loop_out <= 1'b0;
            loop_oe  <= 1'b0;
            busy     <= 1'b0;
            tx_vld   <= 1'b0;
            vld_q    <= '0;
            pass     <= 1'b0;
          end else if (tx_idx == last_idx) begin
            state  <= ST_DRAIN;
            tx_vld <= 1'b0;
          end else begin
            tx_idx   <= tx_idx + 1'b1;
            loop_out <= lfsr[6];
            lfsr     <= prbs_next(lfsr);
          end
        end

        ST_DRAIN: begin
          if (do_abort) begin
            state    <= ST_IDLE;
            loop_out <= 1'b0;
            loop_oe  <= 1'b0;
            busy     <= 1'b0;
            tx_vld   <= 1'b0;
            vld_q    <= '0;
            pass     <= 1'b0;
          end else if (chk_last) begin
            // The final comparison lands on this same edge.
            state    <= ST_DONE;
            done     <= 1'b1;
            pass     <= (err_count == '0) && !chk_err;
            loop_out <= 1'b0;
            loop_oe  <= 1'b0;
            busy     <= 1'b0;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pad_loop_tester.sv
module tb_pad_loop_tester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] length = '0;
  logic [6:0]  seed = '0;
  logic        loop_out;
  logic        loop_oe;
  logic        loop_in = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_count;
  logic [15:0] first_err_idx;

  pad_loop_tester #(.LEN_W(16), .ERR_W(8), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .length(length), .seed(seed), .loop_out(loop_out), .loop_oe(loop_oe),
    .loop_in(loop_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  // Loop modes: 0 ideal, 1 stuck-0, 2 stuck-1, 3 inverted, 4 random flips
  bit mbits [0:1023];
  bit flip  [0:1023];

  typedef struct {
    string     name;
    int        len;
    bit [6:0]  sd;
    int        mode;
    int        x_err;
    int        x_first;
    bit        x_pass;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: PRBS7 as a bit sequence. With the MSB shifted out and
  // x^7+x^6+1 feedback, o[k+7] = o[k] ^ o[k+1], first 7 bits = seed MSB first.
  task automatic model(input int len, input bit [6:0] sd, input int mode,
                       output int err, output int first);
    bit [6:0] s;
    bit r;
    s = (sd == 0) ? 7'h01 : sd;
    for (int k = 0; k < 1024; k++) begin
      if (k < 7) mbits[k] = s[6-k];
      else       mbits[k] = mbits[k-7] ^ mbits[k-6];
    end
    err = 0;
    first = 16'hFFFF;
    for (int k = 0; k < len; k++) begin
      case (mode)
        1: r = 1'b0;
        2: r = 1'b1;
        3: r = ~mbits[k];
        4: r = mbits[k] ^ flip[k];
        default: r = mbits[k];
      endcase
      if (r != mbits[k]) begin
        if (first == 16'hFFFF) first = k;
        err++;
      end
    end
    if (err > 255) err = 255;
  endtask

  function automatic bit rx_bit(input int mode, input bit lo, input int c);
    case (mode)
      1: return 1'b0;
      2: return 1'b1;
      3: return ~lo;
      4: return lo ^ flip[c];
      default: return lo;
    endcase
  endfunction

  task automatic chk_reset(input string nm);
    chk({nm, ".loop_out"}, loop_out, 0);
    chk({nm, ".loop_oe"}, loop_oe, 0);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".pass"}, pass, 0);
    chk({nm, ".err"}, err_count, 0);
    chk({nm, ".first"}, first_err_idx, 16'hFFFF);
  endtask

  task automatic run_test(input string nm, input int len, input bit [6:0] sd,
                          input int mode, input int x_err, input int x_first,
                          input bit x_pass);
    int m_err, m_first, txbad, oebad, c;
    bit seen;
    model(len, sd, mode, m_err, m_first);
    @(negedge clk);
    length = len[15:0];
    seed = sd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    txbad = 0; oebad = 0; seen = 0; c = 0;
    while (!seen && c < len + 10) begin
      if (done) begin
        seen = 1;
      end else begin
        if (!loop_oe || !busy) oebad++;
        if (c < len && loop_out != mbits[c]) txbad++;
        loop_in = rx_bit(mode, loop_out, c);
        @(negedge clk);
        c++;
      end
    end
    if (!seen) begin
      chk({nm, ".done_timeout"}, 0, 1);
    end else begin
      chk({nm, ".done_cycle"}, c, len + 2);
      chk({nm, ".tx_bits_bad"}, txbad, 0);
      chk({nm, ".oe_busy_bad"}, oebad, 0);
      chk({nm, ".oe_at_done"}, loop_oe, 0);
      chk({nm, ".busy_at_done"}, busy, 0);
      chk({nm, ".pass"}, pass, x_pass);
      chk({nm, ".err"}, err_count, x_err);
      chk({nm, ".first"}, first_err_idx, x_first);
      @(negedge clk);
      chk({nm, ".done_one_cycle"}, done, 0);
    end
  endtask

  vec_t vt [7];

  initial begin
    int m_err, m_first, lbad, len;
    bit [6:0] sd;
    int mode;
    bit seen;

    vt[0] = '{"ideal127",   127, 7'h01, 0, 0,   16'hFFFF, 1'b1};
    vt[1] = '{"stuck0",     127, 7'h01, 1, 64,  6,        1'b0};
    vt[2] = '{"invert1000", 1000, 7'h5A, 3, 255, 0,       1'b0};
    vt[3] = '{"seed0_len7", 7,   7'h00, 0, 0,   16'hFFFF, 1'b1};
    vt[4] = '{"stuck1_len7", 7,  7'h01, 2, 6,   0,        1'b0};
    vt[5] = '{"ideal_len1", 1,   7'h40, 0, 0,   16'hFFFF, 1'b1};
    vt[6] = '{"stuck0_len1", 1,  7'h40, 1, 1,   0,        1'b0};

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // start with length 0 is ignored
    length = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("len0.busy", busy, 0);
    chk("len0.oe", loop_oe, 0);

    for (int i = 0; i < 7; i++)
      run_test(vt[i].name, vt[i].len, vt[i].sd, vt[i].mode,
               vt[i].x_err, vt[i].x_first, vt[i].x_pass);

    // results hold after completion
    run_test("stuck0_b", 127, 7'h01, 1, 64, 6, 1'b0);
    repeat (5) @(negedge clk);
    chk("hold.pass", pass, 0);
    chk("hold.err", err_count, 64);
    chk("hold.first", first_err_idx, 6);

    // randomized against the reference model
    for (int i = 0; i < 8; i++) begin
      len  = $urandom_range(1, 300);
      sd   = 7'($urandom_range(0, 127));
      mode = $urandom_range(0, 4);
      for (int k = 0; k < 1024; k++) flip[k] = ($urandom_range(0, 15) == 0);
      model(len, sd, mode, m_err, m_first);
      run_test($sformatf("rand%0d", i), len, sd, mode, m_err, m_first, m_err == 0);
    end

    // abort at cycle 50, extra start at cycle 20
    model(127, 7'h01, 0, m_err, m_first);
    @(negedge clk);
    length = 127; seed = 7'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lbad = 0;
    for (int c = 0; c < 51; c++) begin
      if (loop_out != mbits[c] || !loop_oe) lbad++;
      loop_in = loop_out;
      start = (c == 20);
      abort = (c == 50);
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    chk("abort.bits_before", lbad, 0);
    chk("abort.oe", loop_oe, 0);
    chk("abort.busy", busy, 0);
    chk("abort.loop_out", loop_out, 0);
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (done || busy) seen = 1;
      @(negedge clk);
    end
    chk("abort.no_done", seen, 0);
    chk("abort.pass", pass, 0);
    chk("abort.err", err_count, 0);

    // abort in IDLE ignored; abort+start together: start wins
    abort = 1'b1;
    @(negedge clk);
    chk("idle_abort.busy", busy, 0);
    abort = 1'b0;
    length = 20; seed = 7'h33; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_wins.busy", busy, 1);
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      loop_in = loop_out;
      if (done) seen = 1;
      else @(negedge clk);
    end
    chk("start_wins.done", seen, 1);
    chk("start_wins.pass", pass, 1);

    // async reset mid-run
    @(negedge clk);
    length = 127; seed = 7'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      loop_in = loop_out;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 chk_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_test("after_reset", 127, 7'h01, 0, 0, 16'hFFFF, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pad_loop_tester.md
Name: pad_loop_tester

Overview:
- Built-in self-test for the south-edge pad loopback pair.
- Drives a PRBS7 pattern out of one loop pad (loop_pad_s_6). The pad-ring wiring ties it to the second pad (loop_pad_s_7), where the block samples it back, counts mismatches and records the first failing bit index.
- Sits directly beside the pad-ring wiring macro, in the core domain. Used at bring-up to confirm pad I/O cells and ring wiring.

Parameters:
- LEN_W, 16: width of the length, index and bit counters.
- ERR_W, 8: width of the saturating error counter.
- LATENCY, 2: cycles from loop_out update to the sampled bit appearing at the checker. Equals the number of synchronizer flops on loop_in. Minimum 2.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a test. Accepted only in IDLE.
- abort  input  1  cancels a running test.
- length  input  LEN_W  number of pattern bits. Sampled on start.
- seed  input  7  PRBS7 seed. Sampled on start; 0 is replaced by 7'h01.
- loop_out  output  1  pattern bit to the loop pad output driver.
- loop_oe  output  1  output enable for the loop pad driver.
- loop_in  input  1  raw, asynchronous return from the partner loop pad.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at normal test completion.
- pass  output  1  1 when the last completed test had zero errors.
- err_count  output  ERR_W  mismatch count, saturating at 2^ERR_W-1.
- first_err_idx  output  LEN_W  index of the first mismatched bit. All-ones if there was no error.

Behaviour:

Reset:
- Async, active-low. Every flop clears, including the synchronizer stages.
- Output reset values: loop_out=0, loop_oe=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=all-ones.

PRBS7:
- Polynomial x^7+x^6+1. next = {lfsr[5:0], lfsr[6]^lfsr[5]}.
- Transmitted bit = lfsr[6] before advancing.

States: IDLE, RUN, DRAIN, DONE.

IDLE:
- loop_oe=0, loop_out=0.
- start=1 with length!=0 moves to RUN at the same edge (E0). At E0:
  - lfsr loads the seed.
  - tx counter=0.
  - err_count=0, first_err_idx=all-ones, pass=0.
- start with length==0 is ignored.

RUN:
- loop_oe=1. Bit k is registered onto loop_out at edge Ek, k=0..length-1.
- The same bit enters an expected-bit pipeline of depth LATENCY, together with a valid flag.
- After bit length-1 has been launched, move to DRAIN.
- start is ignored while busy.

Checker:
- loop_in passes through LATENCY synchronizer flops.
- When the pipeline valid output is 1 (bit k, during the cycle after edge E(k+LATENCY)), compare sync_in with the expected bit.
- On mismatch at the next edge:
  - err_count increments, saturating.
  - If first_err_idx is still all-ones, load k.
- An rx index counter tracks k.

DRAIN:
- loop_oe stays 1 and loop_out holds the last bit.
- Lasts until the last valid bit has been checked.

DONE:
- Lasts one cycle. done=1, pass=(err_count==0), loop_oe=0.
- Next state is IDLE.
- done rises at edge E(length+LATENCY).
- pass, err_count and first_err_idx hold until the next accepted start.

Abort:
- In RUN or DRAIN, returns to IDLE at the next edge with loop_oe=0 and the pipeline valid flags cleared.
- No done pulse. pass=0. err_count and first_err_idx keep their partial values.
- Abort in IDLE has no effect. Abort and start in the same IDLE cycle: start wins.

Counters:
- err_count never wraps.
- The tx and rx counters only need to reach length-1; no wrap within a test.

Test Plan:
- Ideal loopback (loop_in=loop_out) with LATENCY=2, seed=7'h01, length=127 → done pulses 129 cycles after the start edge, pass=1, err_count=0, first_err_idx=16'hFFFF, loop_oe=1 exactly across RUN and DRAIN.
- loop_in stuck at 0, length=127, seed=7'h01 → err_count=64, first_err_idx=6, pass=0.
- loop_in inverted, length=1000 → err_count saturates at 255, first_err_idx=0, pass=0, done still pulses.
- seed=0, length=7 with ideal loopback → transmitted bits identical to the seed=7'h01 run (0,0,0,0,0,0,1), pass=1.
- Abort at cycle 50 of a length-127 run, plus a second start at cycle 20 → second start ignored; IDLE and loop_oe=0 one cycle after abort; done never pulses; pass=0.
- rst_n low mid-RUN → all outputs at reset values asynchronously. A fresh start after release runs a clean 127-bit test to pass=1.
